// File: rtl/regfile_if.sv
// regfile_if: writeback, read, reservation and PC signals between the pipeline and regfile.
interface regfile_if;
    logic        wenable;
    logic        fmode;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        pcenable;
    logic [31:0] next_pc;
    logic        rd_en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_f;
    logic        rs2_f;
    logic        rsv_en;
    logic        rsv_f;
    logic [4:0]  rsv_reg;
    logic        rd_valid;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        busy1;
    logic        busy2;
    logic [31:0] pc;

    modport master (
        output wenable, fmode, wreg, wdata, pcenable, next_pc, rd_en, rs1, rs2, rs1_f, rs2_f,
               rsv_en, rsv_f, rsv_reg,
        input  rd_valid, rdata1, rdata2, busy1, busy2, pc
    );
    modport slave (
        input  wenable, fmode, wreg, wdata, pcenable, next_pc, rd_en, rs1, rs2, rs1_f, rs2_f,
               rsv_en, rsv_f, rsv_reg,
        output rd_valid, rdata1, rdata2, busy1, busy2, pc
    );
endinterface

// File: rtl/regfile.sv
// regfile: integer/float banks, PC and pending-write scoreboard with two registered read ports.
// Define REGFILE_FORWARD_EN to bypass same-cycle writeback data onto the read ports.
module regfile #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    logic [31:0] ireg_q [32];
    logic [31:0] ireg_d [32];
    logic [31:0] freg_q [32];
    logic [31:0] freg_d [32];
    logic [31:0] ipend_q, ipend_d, fpend_q, fpend_d;
    logic [31:0] ipend_clr, fpend_clr;
    logic [31:0] iwr_mask, fwr_mask, irsv_mask, frsv_mask;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic        rd_valid_q, rd_valid_d;
    logic        busy1_q, busy1_d, busy2_q, busy2_d;

    always_comb begin
        iwr_mask  = (bus.wenable && !bus.fmode) ? 32'h1 << bus.wreg : '0;
        fwr_mask  = (bus.wenable && bus.fmode) ? 32'h1 << bus.wreg : '0;
        irsv_mask = (bus.rsv_en && !bus.rsv_f) ? 32'h1 << bus.rsv_reg : '0;
        frsv_mask = (bus.rsv_en && bus.rsv_f) ? 32'h1 << bus.rsv_reg : '0;
        ipend_clr = ipend_q & ~iwr_mask;
        fpend_clr = fpend_q & ~fwr_mask;
        // reservation applied after the clear: it belongs to a younger instruction
        ipend_d   = (ipend_clr | irsv_mask) & ~32'h1;
        fpend_d   = fpend_clr | frsv_mask;
        ireg_d    = ireg_q;
        freg_d    = freg_q;
        if (bus.wenable && !bus.fmode && bus.wreg != 5'd0) ireg_d[bus.wreg] = bus.wdata;
        if (bus.wenable && bus.fmode) freg_d[bus.wreg] = bus.wdata;
        pc_d       = bus.pcenable ? bus.next_pc : pc_q;
        rd_valid_d = bus.rd_en;
`ifdef REGFILE_FORWARD_EN
        rdata1_d = bus.rd_en ? (bus.rs1_f ? freg_d[bus.rs1] : ireg_d[bus.rs1]) : rdata1_q;
        rdata2_d = bus.rd_en ? (bus.rs2_f ? freg_d[bus.rs2] : ireg_d[bus.rs2]) : rdata2_q;
`else
        rdata1_d = bus.rd_en ? (bus.rs1_f ? freg_q[bus.rs1] : ireg_q[bus.rs1]) : rdata1_q;
        rdata2_d = bus.rd_en ? (bus.rs2_f ? freg_q[bus.rs2] : ireg_q[bus.rs2]) : rdata2_q;
`endif
        busy1_d = bus.rd_en ? (bus.rs1_f ? fpend_clr[bus.rs1] : ipend_clr[bus.rs1]) : busy1_q;
        busy2_d = bus.rd_en ? (bus.rs2_f ? fpend_clr[bus.rs2] : ipend_clr[bus.rs2]) : busy2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ireg_q     <= '{default: '0};
            freg_q     <= '{default: '0};
            ipend_q    <= '0;
            fpend_q    <= '0;
            pc_q       <= RESET_PC;
            rd_valid_q <= 1'b0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            busy1_q    <= 1'b0;
            busy2_q    <= 1'b0;
        end else begin
            ireg_q     <= ireg_d;
            freg_q     <= freg_d;
            ipend_q    <= ipend_d;
            fpend_q    <= fpend_d;
            pc_q       <= pc_d;
            rd_valid_q <= rd_valid_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            busy1_q    <= busy1_d;
            busy2_q    <= busy2_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.rdata2   = rdata2_q;
    assign bus.busy1    = busy1_q;
    assign bus.busy2    = busy2_q;
    assign bus.pc       = pc_q;
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed plan plus random traffic against an array-based architectural model.
module tb_regfile;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_if bus();
    regfile #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;

    logic [31:0] m_i [32];
    logic [31:0] m_f [32];
    bit          m_ip [32];
    bit          m_fp [32];
    logic [31:0] m_pc;
    logic        e_v, e_b1, e_b2;
    logic [31:0] e_d1, e_d2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic f, input logic [4:0] i);
        return f ? m_f[i] : m_i[i];
    endfunction

    task automatic idle();
        bus.wenable = 0; bus.fmode = 0; bus.wreg = 0; bus.wdata = 0;
        bus.pcenable = 0; bus.next_pc = 0;
        bus.rd_en = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rs1_f = 0; bus.rs2_f = 0;
        bus.rsv_en = 0; bus.rsv_f = 0; bus.rsv_reg = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_i[i] = 0; m_f[i] = 0; m_ip[i] = 0; m_fp[i] = 0;
        end
        m_pc = RST_PC;
        e_v = 0; e_b1 = 0; e_b2 = 0; e_d1 = 0; e_d2 = 0;
    endtask

    task automatic step();
        logic [31:0] r1, r2;
        logic [4:0]  wr;
        wr = bus.wreg;
`ifndef REGFILE_FORWARD_EN
        r1 = rd(bus.rs1_f, bus.rs1);
        r2 = rd(bus.rs2_f, bus.rs2);
`endif
        if (bus.wenable) begin
            if (bus.fmode) begin
                m_f[wr] = bus.wdata; m_fp[wr] = 0;
            end else if (wr != 0) begin
                m_i[wr] = bus.wdata; m_ip[wr] = 0;
            end
        end
`ifdef REGFILE_FORWARD_EN
        r1 = rd(bus.rs1_f, bus.rs1);
        r2 = rd(bus.rs2_f, bus.rs2);
`endif
        if (bus.rd_en) begin
            e_d1 = r1; e_d2 = r2;
            e_b1 = bus.rs1_f ? m_fp[bus.rs1] : m_ip[bus.rs1];
            e_b2 = bus.rs2_f ? m_fp[bus.rs2] : m_ip[bus.rs2];
        end
        e_v = bus.rd_en;
        if (bus.rsv_en) begin
            if (bus.rsv_f) m_fp[bus.rsv_reg] = 1;
            else if (bus.rsv_reg != 0) m_ip[bus.rsv_reg] = 1;
        end
        if (bus.pcenable) m_pc = bus.next_pc;
        @(posedge clk);
        #1;
        chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, e_v});
        chk("rdata1", bus.rdata1, e_d1);
        chk("rdata2", bus.rdata2, e_d2);
        chk("busy1", {31'b0, bus.busy1}, {31'b0, e_b1});
        chk("busy2", {31'b0, bus.busy2}, {31'b0, e_b2});
        chk("pc", bus.pc, m_pc);
        idle();
    endtask

    task automatic do_reset();
        idle();
        bus.rd_en = 1; bus.rs1 = 5; bus.rs2 = 5; bus.rs2_f = 1;
        #2 rst = 1;
        #1;
        chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        chk("rst_rdata1", bus.rdata1, 32'd0);
        chk("rst_rdata2", bus.rdata2, 32'd0);
        chk("rst_busy", {30'b0, bus.busy1, bus.busy2}, 32'd0);
        chk("rst_pc", bus.pc, RST_PC);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_inflight", {31'b0, bus.rd_valid}, 32'd0);
        rst = 0;
        idle();
    endtask

    task automatic rd_set(input logic [4:0] a, input logic af, input logic [4:0] b, input logic bf);
        bus.rd_en = 1; bus.rs1 = a; bus.rs1_f = af; bus.rs2 = b; bus.rs2_f = bf;
    endtask

    task automatic wr_set(input logic f, input logic [4:0] r, input logic [31:0] d);
        bus.wenable = 1; bus.fmode = f; bus.wreg = r; bus.wdata = d;
    endtask

    initial begin
        model_reset();
        do_reset();
        // x5/f5 made nonzero so the mid-run reset is observable
        wr_set(0, 5, 32'h5555_0005); step();
        wr_set(1, 5, 32'h6666_0005); bus.pcenable = 1; bus.next_pc = 32'h40; step();
        do_reset();
        rd_set(5, 0, 5, 1); step();
        chk("reset_x5", bus.rdata1, 32'd0);
        chk("reset_f5", bus.rdata2, 32'd0);
        chk("reset_pc", bus.pc, RST_PC);

        wr_set(0, 3, 32'hDEAD_BEEF); step();
        wr_set(1, 3, 32'h3F80_0000); step();
        rd_set(3, 0, 3, 1); step();
        chk("wr_x3", bus.rdata1, 32'hDEAD_BEEF);
        chk("wr_f3", bus.rdata2, 32'h3F80_0000);
        chk("pulse_hi", {31'b0, bus.rd_valid}, 32'd1);
        step();
        chk("pulse_lo", {31'b0, bus.rd_valid}, 32'd0);
        chk("hold_x3", bus.rdata1, 32'hDEAD_BEEF);

        wr_set(0, 0, 32'h1234_5678); bus.rsv_en = 1; bus.rsv_reg = 0; step();
        rd_set(0, 0, 0, 0); step();
        chk("x0_data", bus.rdata1, 32'd0);
        chk("x0_busy", {31'b0, bus.busy1}, 32'd0);

        bus.rsv_en = 1; bus.rsv_f = 1; bus.rsv_reg = 7; step();
        rd_set(7, 1, 7, 0); step();
        chk("f7_busy", {31'b0, bus.busy1}, 32'd1);
        chk("x7_clear", {31'b0, bus.busy2}, 32'd0);
        wr_set(1, 7, 32'h77); bus.rsv_en = 1; bus.rsv_f = 1; bus.rsv_reg = 7; step();
        rd_set(7, 1, 7, 1); step();
        chk("f7_rersv", {31'b0, bus.busy1}, 32'd1);
        wr_set(1, 7, 32'h78); step();
        rd_set(7, 1, 7, 1); step();
        chk("f7_free", {31'b0, bus.busy1}, 32'd0);

        wr_set(0, 9, 32'h11); step();
        wr_set(0, 9, 32'hAA); rd_set(9, 0, 9, 1); step();
`ifdef REGFILE_FORWARD_EN
        chk("fwd_x9", bus.rdata1, 32'hAA);
`else
        chk("fwd_x9", bus.rdata1, 32'h11);
`endif
        chk("bank_f9", bus.rdata2, 32'd0);

        bus.pcenable = 1; bus.next_pc = 32'h0000_0104; step();
        chk("pc_load", bus.pc, 32'h0000_0104);
        bus.next_pc = 32'hFFFF_0000; step();
        chk("pc_hold", bus.pc, 32'h0000_0104);

        for (int n = 0; n < 1500; n++) begin
            bus.wenable = 1'($urandom_range(0, 1)); bus.fmode = 1'($urandom_range(0, 1));
            bus.wreg = 5'($urandom_range(0, 7)); bus.wdata = $urandom;
            bus.pcenable = ($urandom_range(0, 7) == 0); bus.next_pc = $urandom;
            bus.rd_en = ($urandom_range(0, 3) != 0);
            bus.rs1 = 5'($urandom_range(0, 7)); bus.rs2 = 5'($urandom_range(0, 7));
            bus.rs1_f = 1'($urandom_range(0, 1)); bus.rs2_f = 1'($urandom_range(0, 1));
            bus.rsv_en = 1'($urandom_range(0, 1)); bus.rsv_f = 1'($urandom_range(0, 1));
            bus.rsv_reg = 5'($urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile.md
# regfile

Architectural state holder for the core: 32 integer and 32 float 32-bit registers, the PC register, and a per-register pending-write scoreboard. It is the receiving end of the writeback interface and applies `wenable`/`fmode`/`wreg`/`wdata` and `pcenable`/`next_pc`. It serves two registered read ports to decode. Decode reserves destinations; writeback releases them.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `wenable` in 1: writeback register write strobe.
- `fmode` in 1: write bank select (1 = float, 0 = integer).
- `wreg` in 5: write register index.
- `wdata` in 32: write data.
- `pcenable` in 1: load PC from `next_pc`.
- `next_pc` in 32: new PC value.
- `rd_en` in 1: issue a read on both ports this cycle.
- `rs1`, `rs2` in 5 each: read indices.
- `rs1_f`, `rs2_f` in 1 each: read bank select per port.
- `rsv_en` in 1: mark a destination pending.
- `rsv_f` in 1: bank of the reservation.
- `rsv_reg` in 5: index of the reservation.
- `rd_valid` out 1: read data valid; one-cycle pulse.
- `rdata1`, `rdata2` out 32: read data.
- `busy1`, `busy2` out 1: source was pending when sampled.
- `pc` out 32: current PC.

## Operation
- Storage: `ireg[0..31]` and `freg[0..31]`, 32 bits each, plus `ipend[31:0]` and `fpend[31:0]`.
- Integer x0:
  - reads 0;
  - writes to it are dropped;
  - reservations on it are dropped;
  - `ipend[0]` is always 0.
- `f0` is an ordinary register.
- Write: when `wenable`=1, the selected bank entry `wreg` takes `wdata`, and the matching pending bit clears.
- Reserve: when `rsv_en`=1, the selected pending bit sets.
- Same register reserved and cleared in one cycle: the reservation wins and the bit stays 1, because it belongs to a younger instruction.
- Read: when `rd_en`=1, the next cycle shows:
  - `rd_valid`=1;
  - `rdata1`/`rdata2` holding the sampled registers;
  - `busy1`/`busy2` holding the pending bits sampled that cycle, after same-cycle writeback clears and before same-cycle reservations.
- When `rd_en`=0, `rd_valid` drops next cycle and `rdata*`/`busy*` hold their last values.
- PC: when `pcenable`=1, `pc` takes `next_pc` on the next edge. Otherwise it holds.
- The scoreboard only reports. Stalling is decode's decision.

## Timing
- Reset (asynchronous, immediate):
  - all registers 0;
  - pending bits 0;
  - `rd_valid`=0;
  - `rdata1`/`rdata2`=0;
  - `busy1`/`busy2`=0;
  - `pc`=`RESET_PC`.
- Reset asserted with a read in flight: the read is lost and `rd_valid` stays 0.
- Read latency is 1 cycle, with full throughput: back-to-back `rd_en` gives back-to-back `rd_valid`.
- Write latency: visible to a read issued on the following cycle in all configurations.
- Same-cycle write and read to the same bank and index: depends on the Configuration section below.
- A write and a read to the same index but different banks do not interact.
- `rs1` equal to `rs2` is legal; both ports return the same value.

## Configuration
- Macro: `REGFILE_FORWARD_EN`.
- Defined: a read sampling the same bank and index as a same-cycle `wenable` write returns `wdata`. The corresponding `busy` reports 0, since the clear is applied.
- Undefined: that read returns the old register contents. `busy` still reflects the cleared bit.
- Undefined is the area-minimal variant; decode must then insert one bubble.

## Test plan
- Reset check: apply reset mid-run, then read int x5 and f5 -> rdata1=0 and rdata2=0, and `pc`=`RESET_PC`.
- Write and read back:
  - write int x3=32'hDEAD_BEEF and f3=32'h3F80_0000;
  - one cycle later, read `rs1`=3/int and `rs2`=3/float;
  - -> rdata1=DEADBEEF, rdata2=3F800000, `rd_valid` a one-cycle pulse.
- x0 protection: write int x0=32'h1234_5678 and reserve x0, then read x0 -> rdata=0, busy=0.
- Scoreboard:
  - reserve f7, then read f7 -> busy1=1;
  - write f7 with a same-cycle re-reserve of f7 -> the bit stays set;
  - write f7 alone, then read -> busy1=0.
- Same-cycle forward: write int x9=32'h0000_00AA while reading x9, with x9 previously 32'h11 -> rdata1=AA with `REGFILE_FORWARD_EN` defined, 11 without.
- PC: pulse `pcenable` with `next_pc`=32'h0000_0104 -> `pc`=104 on the next edge; `pc` holds while `pcenable`=0.
